mmc_cmd_serialiser: RTL and testbench

MMC_CMD_SERIALISER -- requirements
Module: mmc_cmd_serialiser

---
 rtl/mmc_cmd_serialiser.sv | 209 ++++++++++++++++++++
 tb/tb_mmc_cmd_serialiser.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_cmd_serialiser.sv
// ---------------------------------------------------------------------------
// mmc_cmd_serialiser
//
// Serialises one 48-bit MMC command frame onto the CMD line:
//   {start 0, transmit 1, cmd_idx[5:0], arg[31:0], crc7[6:0], end 1}
// Bits go out MSB first. Each bit is launched on a falling edge of the MMC
// bus clock (bitclk_i), which is sampled in the clk_i domain. After the end
// bit has been held for one full bit period the line is released. The block
// then raises a one-cycle completion pulse and, if a response is expected,
// starts the response deserialiser.
//
// Optional feature (macro MMC_CMD_SERIALISER_CRC7_EN):
//   defined   - CRC7 (x^7 + x^3 + 1, init 0) is generated internally over
//               frame bits 47..8 while they are shifted out; crc_i is ignored.
//   undefined - the CRC field is the crc_i value captured with the command.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         asynchronous reset, active low
//   bitclk_i      MMC bus clock level (synchronous to clk_i, <= clk_i/2)
//   start_i       one-cycle command request, accepted only when idle
//   abort_i       cancel any transfer in progress (wins over start_i)
//   cmd_idx_i     command index     } captured
//   arg_i         command argument  } on an
//   crc_i         external CRC7     } accepted
//   resp_type_i   0 none, 1 48-bit, 2 136-bit (R2), 3 as 1 } start_i
//   cmd_o         CMD line data (idles high)
//   cmd_oe_o      CMD line output enable
//   busy_o        transfer in progress
//   done_o        one-cycle completion pulse
//   resp_start_o  one-cycle response-start pulse, with done_o, if a response
//                 is expected
//   resp_r2_o     captured response type is R2; held until the next start
// ---------------------------------------------------------------------------
module mmc_cmd_serialiser (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bitclk_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] arg_i,
    input  logic [6:0]  crc_i,
    input  logic [1:0]  resp_type_i,
    output logic        cmd_o,
    output logic        cmd_oe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        resp_start_o,
    output logic        resp_r2_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        bitclk_q;
    logic        fall_w;
    logic [47:0] frame_q;
    logic [5:0]  count_q;
    logic [1:0]  resp_type_q;
    logic        cur_bit;
    logic [6:0]  crc_load;

    // Strobes from the control process into the datapath register.
    logic        load_en;
    logic        shift_en;
    logic        release_en;

    assign fall_w  = ~bitclk_i & bitclk_q;
    assign cur_bit = frame_q[count_q];

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge value of the others, as real hardware does.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bitclk_q <= 1'b0;
        end else begin
            bitclk_q <= bitclk_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        load_en      = 1'b0;
        shift_en     = 1'b0;
        release_en   = 1'b0;
        done_o       = 1'b0;
        resp_start_o = 1'b0;

        // The completion pulse is a pure decode of the DONE state.
        if (state_q == ST_DONE) begin
            done_o       = 1'b1;
            resp_start_o = (resp_type_q != 2'd0);
        end

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A fall_w in this same cycle is deliberately not used.
                    if (start_i) begin
                        load_en = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (fall_w) begin
                        shift_en = 1'b1;
                        if (count_q == 6'd0) begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    // Holding until the next fall gives the end bit a full
                    // bit period on the line.
                    if (fall_w) begin
                        release_en = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

`ifdef MMC_CMD_SERIALISER_CRC7_EN
    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       crc_ins;
    logic       unused_crc_i;

    assign unused_crc_i = ^crc_i;
    // The CRC field loads as zero; the computed remainder is written in later.
    assign crc_load = 7'd0;
    assign crc_d    = {crc_q[5:0], 1'b0} ^ ((cur_bit ^ crc_q[6]) ? 7'h09 : 7'h00);
    // Bit 8 is the last covered bit; its update lands the remainder in
    // frame[7:1] one bit period before bit 7 is needed.
    assign crc_ins  = shift_en && (count_q == 6'd8);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            crc_q <= 7'd0;
        end else if (load_en) begin
            crc_q <= 7'd0;
        end else if (shift_en && (count_q >= 6'd8)) begin
            crc_q <= crc_d;
        end
    end
`else
    assign crc_load = crc_i;
`endif

    // NOTE: the frame shift register is reset along with the control flops so
    // the block comes out of reset in a fully defined state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frame_q     <= '0;
            count_q     <= 6'd0;
            resp_type_q <= 2'd0;
            cmd_o       <= 1'b1;
            cmd_oe_o    <= 1'b0;
        end else begin
            if (load_en) begin
                frame_q     <= {2'b01, cmd_idx_i, arg_i, crc_load, 1'b1};
                count_q     <= 6'd47;
                resp_type_q <= resp_type_i;
            end
            if (shift_en) begin
                cmd_o    <= cur_bit;
                cmd_oe_o <= 1'b1;
                if (count_q != 6'd0) begin
                    count_q <= count_q - 6'd1;
                end
            end
`ifdef MMC_CMD_SERIALISER_CRC7_EN
            if (crc_ins) begin
                frame_q[7:1] <= crc_d;
            end
`endif
            if (release_en || abort_i) begin
                cmd_oe_o <= 1'b0;
                cmd_o    <= 1'b1;
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign resp_r2_o = (resp_type_q == 2'd2);

endmodule

// File: tb/tb_mmc_cmd_serialiser.sv
// ---------------------------------------------------------------------------
// tb_mmc_cmd_serialiser
//
// Directed and randomised commands are sent through mmc_cmd_serialiser. A
// passive monitor captures the CMD line on rising edges of the bus clock and
// records when the output enable rises and falls and when done_o pulses.
// Expected frames come from a polynomial-division CRC7 model, and expected
// timing comes from the known phase of the generated bus clock.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mmc_cmd_serialiser;

    localparam longint BIT_NS  = 40;   // bus clock period (4 clk_i cycles)
    localparam longint FALL0   = 45;   // first clk_i edge that sees fall_w

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b0;
    logic        bitclk_i    = 1'b0;
    logic        start_i     = 1'b0;
    logic        abort_i     = 1'b0;
    logic [5:0]  cmd_idx_i   = '0;
    logic [31:0] arg_i       = '0;
    logic [6:0]  crc_i       = '0;
    logic [1:0]  resp_type_i = '0;
    logic        cmd_o, cmd_oe_o, busy_o, done_o, resp_start_o, resp_r2_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state (written only by the monitor processes).
    logic [47:0] cap        = '0;
    int          cap_n      = 0;
    int          done_n     = 0;
    int          rs_n       = 0;
    logic        rs_at_done = 1'b0;
    longint      t_oe_rise  = 0;
    longint      t_oe_fall  = 0;
    longint      t_done     = 0;

    mmc_cmd_serialiser dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bitclk_i     (bitclk_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .cmd_idx_i    (cmd_idx_i),
        .arg_i        (arg_i),
        .crc_i        (crc_i),
        .resp_type_i  (resp_type_i),
        .cmd_o        (cmd_o),
        .cmd_oe_o     (cmd_oe_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .resp_start_o (resp_start_o),
        .resp_r2_o    (resp_r2_o)
    );

    // clk_i rises at 5, 15, 25 ...; bitclk_i toggles at 22, 42, 62 ... and
    // falls at 42 + 40k, so fall_w is seen on the clk_i edges at 45 + 40k.
    always #5 clk_i = ~clk_i;
    initial begin
        #2;
        forever #20 bitclk_i = ~bitclk_i;
    end

    always @(posedge bitclk_i) begin
        if (cmd_oe_o === 1'b1) begin
            cap   = {cap[46:0], cmd_o};
            cap_n = cap_n + 1;
        end
    end
    always @(posedge cmd_oe_o) t_oe_rise = $time;
    always @(negedge cmd_oe_o) t_oe_fall = $time;
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            done_n     = done_n + 1;
            t_done     = $time;
            rs_at_done = resp_start_o;
        end
        if (resp_start_o === 1'b1) rs_n = rs_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7 + x^3 + 1 (0x89).
    function automatic logic [6:0] crc7_div(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg,
                                                input logic [6:0] crc);
        logic [6:0] c;
`ifdef MMC_CMD_SERIALISER_CRC7_EN
        c = crc7_div({2'b01, idx, arg});
`else
        c = crc;
`endif
        return {2'b01, idx, arg, c, 1'b1};
    endfunction

    // Send one command and check frame contents, pulses and timing.
    // coincide: start_i lands on a fall_w edge. dup: extra start_i pulses
    // during SHIFT and in the DONE cycle, which must be ignored.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                        input logic [1:0] rt, input bit coincide, input bit dup,
                        input bit use_gold, input logic [47:0] gold);
        logic [47:0] exp_frame;
        longint      t_acc, e1;
        int          cap0, done0, rs0;
        bit          seen;
        exp_frame = model_frame(idx, arg, crc);
        repeat ($urandom_range(0, 5)) @(negedge clk_i);
        if (coincide) @(negedge bitclk_i);
        else          @(negedge clk_i);
        cmd_idx_i   = idx;
        arg_i       = arg;
        crc_i       = crc;
        resp_type_i = rt;
        start_i     = 1'b1;
        cap0  = cap_n;
        done0 = done_n;
        rs0   = rs_n;
        @(posedge clk_i);
        t_acc = $time;
        #1;
        start_i     = 1'b0;
        cmd_idx_i   = 6'($urandom);
        arg_i       = $urandom;
        crc_i       = 7'($urandom);
        resp_type_i = 2'($urandom);
        check("busy_after_start", {63'd0, busy_o}, 64'd1);
        check("resp_r2_on_start", {63'd0, resp_r2_o}, {63'd0, rt == 2'd2});
        e1 = FALL0;
        while (e1 <= t_acc) e1 += BIT_NS;
        if (dup) begin
            repeat (60) @(negedge clk_i);
            cmd_idx_i = ~idx;
            start_i   = 1'b1;
            @(negedge clk_i);
            start_i   = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk_i);
            seen = (done_o === 1'b1);
        end
        check("done_within_budget", {63'd0, seen}, 64'd1);
        if (dup && seen) begin
            start_i = 1'b1;
            @(posedge clk_i);
            #1 start_i = 1'b0;
        end
        repeat (8) @(negedge clk_i);
        check("frame_vs_model", {16'd0, cap}, {16'd0, exp_frame});
        if (use_gold) check("frame_vs_golden", {16'd0, cap}, {16'd0, gold});
        check("bits_driven", 64'(cap_n - cap0), 64'd48);
        check("done_pulses", 64'(done_n - done0), 64'd1);
        check("resp_start_pulses", 64'(rs_n - rs0), {63'd0, rt != 2'd0});
        check("resp_start_with_done", {63'd0, rs_at_done}, {63'd0, rt != 2'd0});
        check("resp_r2_after_done", {63'd0, resp_r2_o}, {63'd0, rt == 2'd2});
        check("first_bit_time", 64'(t_oe_rise), 64'(e1));
        check("release_time", 64'(t_oe_fall), 64'(e1 + 48 * BIT_NS));
        check("done_time", 64'(t_done), 64'(e1 + 48 * BIT_NS + 5));
        check("idle_busy", {63'd0, busy_o}, 64'd0);
        check("idle_oe", {63'd0, cmd_oe_o}, 64'd0);
        check("idle_cmd", {63'd0, cmd_o}, 64'd1);
    endtask

    initial begin
        int cap0, done0;

        // Reset state.
        #10;
        check("rst_cmd", {63'd0, cmd_o}, 64'd1);
        check("rst_oe", {63'd0, cmd_oe_o}, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_resp_start", {63'd0, resp_start_o}, 64'd0);
        check("rst_resp_r2", {63'd0, resp_r2_o}, 64'd0);
        #13 rst_i = 1'b1;

        // Directed frames.
`ifdef MMC_CMD_SERIALISER_CRC7_EN
        send(6'd0, 32'h0, 7'h55, 2'd0, 1'b0, 1'b0, 1'b1, 48'h400000000095);
        send(6'd8, 32'h1AA, 7'h00, 2'd1, 1'b1, 1'b1, 1'b1, 48'h48000001AA87);
        send(6'd2, 32'h0, 7'h00, 2'd2, 1'b0, 1'b0, 1'b1, 48'h42000000004D);
`else
        send(6'd17, 32'h0, 7'h15, 2'd0, 1'b0, 1'b0, 1'b1, 48'h51000000002B);
        send(6'd8, 32'h1AA, 7'h43, 2'd1, 1'b1, 1'b1, 1'b0, 48'h0);
        send(6'd2, 32'h0, 7'h26, 2'd2, 1'b0, 1'b0, 1'b0, 48'h0);
`endif
        // Response type 3 behaves as a 48-bit response.
        send(6'd13, 32'hDEAD_BEEF, 7'h11, 2'd3, 1'b1, 1'b0, 1'b0, 48'h0);

        // Abort after 20 bits.
        @(negedge clk_i);
        cmd_idx_i   = 6'd24;
        arg_i       = $urandom;
        resp_type_i = 2'd1;
        start_i     = 1'b1;
        cap0  = cap_n;
        done0 = done_n;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 2000 && (cap_n - cap0) < 20; i++) @(negedge clk_i);
        check("abort_reached_20_bits", {63'd0, (cap_n - cap0) >= 20}, 64'd1);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        check("abort_oe", {63'd0, cmd_oe_o}, 64'd0);
        check("abort_cmd", {63'd0, cmd_o}, 64'd1);
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        repeat (300) @(negedge clk_i);
        check("abort_no_done", 64'(done_n - done0), 64'd0);
        check("abort_line_quiet", {63'd0, cmd_oe_o}, 64'd0);

        // Abort wins over a simultaneous start.
        @(negedge clk_i);
        abort_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        start_i = 1'b0;
        check("abort_beats_start", {63'd0, busy_o}, 64'd0);
        repeat (100) @(negedge clk_i);
        check("abort_beats_start_oe", {63'd0, cmd_oe_o}, 64'd0);

        // Randomised commands (the first also shows start works after abort).
        for (int n = 0; n < 8; n++) begin
            send(6'($urandom), $urandom, 7'($urandom), 2'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 48'h0);
        end

        // Asynchronous reset in the middle of a transfer.
        @(negedge clk_i);
        cmd_idx_i   = 6'd9;
        arg_i       = $urandom;
        resp_type_i = 2'd2;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("r2_before_reset", {63'd0, resp_r2_o}, 64'd1);
        check("oe_before_reset", {63'd0, cmd_oe_o}, 64'd1);
        done0 = done_n;
        #3 rst_i = 1'b0;
        #1;
        check("midrst_oe", {63'd0, cmd_oe_o}, 64'd0);
        check("midrst_cmd", {63'd0, cmd_o}, 64'd1);
        check("midrst_busy", {63'd0, busy_o}, 64'd0);
        check("midrst_r2", {63'd0, resp_r2_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (300) @(negedge clk_i);
        check("midrst_no_done", 64'(done_n - done0), 64'd0);
        check("midrst_line_quiet", {63'd0, cmd_oe_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
